// File: rtl/link_rx_deframer.sv
// link_rx_deframer
//   Receive-side deframer for the 9-bit chip-to-platform result link.
//   The toggle strobe is synchronised into clk. Each level change captures
//   rx_byte. BYTES_PER_FRAME bytes are assembled MSB-byte-first into one
//   result word, which is presented with a one-cycle result_valid pulse.
//
// Optional feature macro: LINK_RX_TIMEOUT_EN
//   defined   : a partial frame idle for TIMEOUT_CYCLES is discarded,
//               pulsing frame_err and bumping err_cnt (saturating).
//   undefined : no timeout; frame_err and err_cnt are tied to 0.
//
// Ports
//   clk          platform clock
//   rst_n        synchronous active-low reset
//   rx_shake     toggle strobe from the chip (asynchronous)
//   rx_byte      byte lines, held stable by the sender around each toggle
//   result_data  last complete word, first byte in the top 8 bits
//   result_valid one-cycle pulse when result_data is new
//   busy         high while a frame is partially received
//   frame_err    one-cycle pulse when a stalled frame is discarded
//   frame_cnt    completed frames (wrapping)
//   err_cnt      discarded frames (saturating)
module link_rx_deframer #(
    parameter int BYTES_PER_FRAME = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_shake,
    input  logic [7:0]                   rx_byte,
    output logic [8*BYTES_PER_FRAME-1:0] result_data,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         frame_err,
    output logic [31:0]                  frame_cnt,
    output logic [15:0]                  err_cnt
);
    localparam int DATA_W = 8 * BYTES_PER_FRAME;
    localparam int BCNT_W = $clog2(BYTES_PER_FRAME + 1);
    localparam int ARM_W  = $clog2(SYNC_STAGES + 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);

    // Elaboration-time guard on parameter minimums.
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2 || BYTES_PER_FRAME < 1) begin : g_param_check
        $error("link_rx_deframer: parameter below minimum");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [SYNC_STAGES-1:0]   sync_r;
    logic                     prev_r;
    logic [ARM_W-1:0]         arm_cnt_r;
    logic                     armed_r;
    logic                     edge_s;
    logic [BCNT_W-1:0]        byte_cnt_r;
    logic [DATA_W-1:0]        asm_r;
    logic [DATA_W-1:0]        asm_next_s;
    logic                     capture_s;
    logic                     complete_s;
    logic                     timeout_s;
    logic                     tmo_hit_s;
    logic [DATA_W-1:0]        result_data_r;
    logic                     result_valid_r;
    logic                     busy_r;
    logic [31:0]              frame_cnt_r;

`ifdef LINK_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             frame_err_r;
    logic [15:0]      err_cnt_r;
    // Terminal count reached: TIMEOUT_CYCLES edges since the last capture.
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
    assign frame_err = frame_err_r;
    assign err_cnt   = err_cnt_r;
`else
    assign tmo_hit_s = 1'b0;
    assign frame_err = 1'b0;
    assign err_cnt   = 16'h0000;
`endif

    // The arming mask hides the apparent level change while the
    // synchroniser fills from its reset value after reset.
    assign edge_s     = armed_r & (sync_r[SYNC_STAGES-1] ^ prev_r);
    assign asm_next_s = (asm_r << 8'd8) | DATA_W'(rx_byte);

    assign result_data  = result_data_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign frame_cnt    = frame_cnt_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle capture/complete/timeout decisions.
    // An edge in the timeout-terminal cycle takes priority over the timeout.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        complete_s   = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    capture_s = 1'b1;
                    if (byte_cnt_r == LAST_BYTE) begin
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (edge_s) begin
                    capture_s = 1'b1;
                    if (byte_cnt_r == LAST_BYTE) begin
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else if (tmo_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RECV;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Synchroniser, arming, byte assembly and result/frame counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r         <= {SYNC_STAGES{1'b0}};
            prev_r         <= 1'b0;
            arm_cnt_r      <= {ARM_W{1'b0}};
            armed_r        <= 1'b0;
            byte_cnt_r     <= {BCNT_W{1'b0}};
            asm_r          <= {DATA_W{1'b0}};
            result_data_r  <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            frame_cnt_r    <= 32'd0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], rx_shake};
            prev_r  <= sync_r[SYNC_STAGES-1];
            if (arm_cnt_r != ARM_LAST) begin
                arm_cnt_r <= arm_cnt_r + ARM_W'(1);
            end
            armed_r <= armed_r | (arm_cnt_r == ARM_LAST);

            if (complete_s || timeout_s) begin
                asm_r      <= {DATA_W{1'b0}};
                byte_cnt_r <= {BCNT_W{1'b0}};
            end else if (capture_s) begin
                asm_r      <= asm_next_s;
                byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
            end

            result_valid_r <= complete_s;
            if (complete_s) begin
                result_data_r <= asm_next_s;
                frame_cnt_r   <= frame_cnt_r + 32'd1;
            end
            busy_r <= (state_next_s == ST_RECV);
        end
    end

`ifdef LINK_RX_TIMEOUT_EN
    // Inter-byte idle counter plus discard pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_r   <= {TMO_W{1'b0}};
            frame_err_r <= 1'b0;
            err_cnt_r   <= 16'h0000;
        end else begin
            if (state_r == ST_RECV && !edge_s && !timeout_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            frame_err_r <= timeout_s;
            if (timeout_s && err_cnt_r != 16'hFFFF) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_link_rx_deframer.sv
module tb_link_rx_deframer;
    localparam int TMO = 20;

    logic         clk;
    logic         rst_n;
    logic         rx_shake;
    logic [7:0]   rx_byte;
    logic [127:0] result_data;
    logic         result_valid;
    logic         busy;
    logic         frame_err;
    logic [31:0]  frame_cnt;
    logic [15:0]  err_cnt;

    link_rx_deframer #(
        .BYTES_PER_FRAME(16),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_shake(rx_shake),
        .rx_byte(rx_byte),
        .result_data(result_data),
        .result_valid(result_valid),
        .busy(busy),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: every cycle with result_valid / frame_err is logged.
    logic [127:0] valid_q[$];
    int           valid_cyc_q[$];
    int           err_cyc_q[$];
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            valid_q.push_back(result_data);
            valid_cyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) err_cyc_q.push_back(cyc);
    end

    int           n_pass = 0;
    int           n_chk  = 0;
    int           exp_frames;
    int           exp_err;
    logic [127:0] exp_last;
    int           last_tog;

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        int           gap;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        repeat (ncyc) tick();
        rst_n = 1'b1;
        exp_frames = 0;
        exp_err    = 0;
        exp_last   = 128'h0;
    endtask

    // One toggle with its byte, then gap cycles before returning.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_shake = ~rx_shake;
        last_tog = cyc;
        repeat (gap) tick();
    endtask

    // Exactly one new word w, latched 3 edges after the last toggle.
    task automatic expect_frame(input string name, input logic [127:0] w, input int vmark);
        repeat (5) tick();
        exp_frames++;
        exp_last = w;
        chk({name, " valid count"}, valid_q.size() - vmark, 128'd1);
        if (valid_q.size() > vmark) begin
            chk({name, " valid data"}, valid_q[vmark], w);
            chk({name, " valid latency"}, valid_cyc_q[vmark], last_tog + 3);
        end
        chk({name, " frame_cnt"}, frame_cnt, exp_frames);
        chk({name, " busy"}, busy, 128'd0);
        chk({name, " result_data"}, result_data, w);
    endtask

    int           vmark;
    int           emark;
    int           nb;
    bit           abort_f;
    logic [7:0]   b;
    logic [127:0] w;

    initial begin
        tbl[0] = '{8'h00, 8'h01, 10, 128'h000102030405060708090A0B0C0D0E0F};
        tbl[1] = '{8'hA0, 8'h01, 3,  128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF};
        tbl[2] = '{8'h10, 8'h11, 4,  128'h102132435465768798A9BACBDCEDFE0F};
        tbl[3] = '{8'h5A, 8'h00, 7,  128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A};
        tbl[4] = '{8'hFF, 8'h00, TMO, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF};

        rx_shake = 1'b1;
        rx_byte  = 8'h00;
        do_reset(3);
        tick();
        chk("reset result_data", result_data, 128'd0);
        chk("reset result_valid", result_valid, 128'd0);
        chk("reset busy", busy, 128'd0);
        chk("reset frame_err", frame_err, 128'd0);
        chk("reset frame_cnt", frame_cnt, 128'd0);
        chk("reset err_cnt", err_cnt, 128'd0);

        // Strobe high through reset release must not produce a byte.
        repeat (100) tick();
        chk("idle high no valid", valid_q.size(), 128'd0);
        chk("idle high busy", busy, 128'd0);
        chk("idle high frame_cnt", frame_cnt, 128'd0);

        // Table-driven full frames.
        for (int r = 0; r < 5; r++) begin
            vmark = valid_q.size();
            emark = err_cyc_q.size();
            for (int i = 0; i < 16; i++) begin
                b = tbl[r].base + tbl[r].step * 8'(i);
                send_byte(b, tbl[r].gap);
                if (i == 7) chk($sformatf("tbl%0d busy mid", r), busy, 128'd1);
            end
            expect_frame($sformatf("tbl%0d", r), tbl[r].exp, vmark);
            chk($sformatf("tbl%0d no err", r), err_cyc_q.size() - emark, 128'd0);
        end

        // Stall after 5 bytes.
        vmark = valid_q.size();
        emark = err_cyc_q.size();
        w = 128'h0;
        for (int i = 0; i < 5; i++) begin
            b = 8'h30 + 8'(i);
            w[127-8*i -: 8] = b;
            send_byte(b, 5);
        end
        tick();
        chk("stall busy", busy, 128'd1);
`ifdef LINK_RX_TIMEOUT_EN
        repeat (40) tick();
        exp_err++;
        chk("timeout err pulses", err_cyc_q.size() - emark, 128'd1);
        if (err_cyc_q.size() > emark)
            chk("timeout err latency", err_cyc_q[emark], last_tog + 3 + TMO);
        chk("timeout err_cnt", err_cnt, exp_err);
        chk("timeout busy", busy, 128'd0);
        chk("timeout result_data kept", result_data, exp_last);
        chk("timeout no valid", valid_q.size() - vmark, 128'd0);
        vmark = valid_q.size();
        w = 128'h0;
        for (int i = 0; i < 16; i++) begin
            b = 8'hA0 + 8'(i);
            w[127-8*i -: 8] = b;
            send_byte(b, 4);
        end
        expect_frame("after timeout", w, vmark);
`else
        repeat (300) tick();
        chk("no-timeout busy held", busy, 128'd1);
        chk("no-timeout no err", err_cyc_q.size() - emark, 128'd0);
        chk("no-timeout err_cnt", err_cnt, 128'd0);
        for (int i = 5; i < 16; i++) begin
            b = 8'hA0 + 8'(i);
            w[127-8*i -: 8] = b;
            send_byte(b, 4);
        end
        expect_frame("no-timeout resume", w, vmark);
`endif

        // Third byte captured exactly in the timeout-terminal cycle.
        vmark = valid_q.size();
        emark = err_cyc_q.size();
        w = 128'h0;
        for (int i = 0; i < 16; i++) begin
            b = 8'hB0 + 8'(i);
            w[127-8*i -: 8] = b;
            send_byte(b, (i == 1) ? TMO : 4);
        end
        expect_frame("terminal edge", w, vmark);
        chk("terminal edge no err", err_cyc_q.size() - emark, 128'd0);

        // Reset mid-frame drops the partial frame silently.
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 5);
        emark = err_cyc_q.size();
        do_reset(1);
        tick();
        chk("midreset frame_cnt", frame_cnt, 128'd0);
        chk("midreset err_cnt", err_cnt, 128'd0);
        chk("midreset result_data", result_data, 128'd0);
        chk("midreset busy", busy, 128'd0);
        repeat (40) tick();
        chk("midreset no err", err_cyc_q.size() - emark, 128'd0);
        vmark = valid_q.size();
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 6);
        expect_frame("midreset ones", {128{1'b1}}, vmark);

        // Randomised frames against the byte-placement model.
        for (int f = 0; f < 12; f++) begin
            abort_f = 1'b0;
`ifdef LINK_RX_TIMEOUT_EN
            abort_f = ($urandom_range(0, 3) == 0);
`endif
            nb = abort_f ? int'($urandom_range(1, 15)) : 16;
            vmark = valid_q.size();
            emark = err_cyc_q.size();
            w = 128'h0;
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                w[127-8*i -: 8] = b;
                send_byte(b, int'($urandom_range(3, 15)));
            end
            if (abort_f) begin
                repeat (30) tick();
                exp_err++;
                chk($sformatf("rand%0d err pulse", f), err_cyc_q.size() - emark, 128'd1);
                chk($sformatf("rand%0d err_cnt", f), err_cnt, exp_err);
                chk($sformatf("rand%0d data kept", f), result_data, exp_last);
                chk($sformatf("rand%0d no valid", f), valid_q.size() - vmark, 128'd0);
            end else begin
                expect_frame($sformatf("rand%0d", f), w, vmark);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/link_rx_deframer.md
# link_rx_deframer

Receive-side deframer for the 9-bit chip-to-platform result link (8 data lines plus one toggle strobe). It synchronises the strobe into the platform clock domain, captures one byte per strobe toggle, assembles a fixed number of bytes (MSB byte first) into one result word, and presents it as a single-cycle valid pulse to the result checker. A partial frame that stalls past a timeout is discarded and counted as a framing error.

## Interface
Parameters:
- BYTES_PER_FRAME, 16, bytes per result word; data width is 8*BYTES_PER_FRAME
- SYNC_STAGES, 2, flip-flop stages on the strobe synchroniser (min 2)
- TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes inside a frame (min 2)

Ports:
- clk  input  1  platform clock; the only clock
- rst_n  input  1  synchronous, active-low reset
- rx_shake  input  1  toggle strobe from chip; each level change announces a new byte
- rx_byte  input  8  byte lines; sender holds them stable from before a toggle until the next toggle
- result_data  output  8*BYTES_PER_FRAME  last complete word; first received byte in bits [MSB:MSB-7]
- result_valid  output  1  one-cycle pulse, result_data new
- busy  output  1  high while a frame is partially received
- frame_err  output  1  one-cycle pulse on timeout discard
- frame_cnt  output  32  completed frames, wraps at 2^32
- err_cnt  output  16  discarded frames, saturates at 16'hFFFF

## Operation
- Synchroniser: rx_shake passes through SYNC_STAGES flops s[0..S-1]; prev holds last s[S-1]; edge = armed & (s[S-1] ^ prev).
- Arming: after reset, armed=0 and prev tracks s[S-1] for SYNC_STAGES+1 cycles; then armed=1. Idle line level at reset never produces a byte.
- On edge: rx_byte sampled directly (no data synchroniser; stability guaranteed by sender), shifted into assembly register, byte_cnt++.
- States: IDLE (byte_cnt=0, busy=0) -> RECV on first edge; RECV -> IDLE on edge that completes byte BYTES_PER_FRAME (result_data loaded, result_valid pulsed, frame_cnt++); RECV -> IDLE on timeout (assembly discarded, frame_err pulsed, err_cnt++ unless saturated).
- Timeout counter cleared on every edge and in IDLE; counts only in RECV.
- Edge and timeout terminal in same cycle: edge wins, timeout counter cleared, no error.
- result_data holds value until next complete frame; never altered by discarded frames.
- Single-byte frame (BYTES_PER_FRAME=1): every edge completes a frame; IDLE -> IDLE.

## Timing
- Reset values: result_data 0, result_valid 0, busy 0, frame_err 0, frame_cnt 0, err_cnt 0, byte_cnt 0, armed 0, all sync flops 0.
- rx_shake change settled before clk edge N: byte captured at edge N+SYNC_STAGES; for the last byte result_valid and new result_data visible after that same edge, for exactly one cycle.
- Max strobe rate: one toggle per SYNC_STAGES+1 clk cycles; faster toggles are outside spec.
- Timeout: frame_err asserted after edge TIMEOUT_CYCLES counted from the last capture edge in RECV.
- Reset mid-frame: partial frame dropped silently (no frame_err, no err_cnt change); re-arming applies.

## Configuration
- LINK_RX_TIMEOUT_EN defined: timeout counter, frame_err and err_cnt behave as above.
- Not defined: no timeout logic; RECV waits indefinitely; frame_err tied 0, err_cnt tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Reset, 16 toggles with bytes 8'h00..8'h0F spaced 10 cycles -> one result_valid, result_data 128'h000102030405060708090A0B0C0D0E0F, frame_cnt 1, busy low after.
- rx_shake held at 1 through reset release, no toggles for 100 cycles -> no capture, busy 0, frame_cnt 0.
- TIMEOUT_CYCLES=20, 5 bytes then silence -> frame_err pulse 20 cycles after 5th capture, err_cnt 1, result_data unchanged; next 16 bytes 8'hA0..8'hAF -> valid word 128'hA0A1..AF.
- Byte 3 toggle arriving in the timeout-terminal cycle -> captured, no frame_err, frame completes normally.
- rst_n low for 1 cycle after byte 8 -> counters 0, no frame_err; following full frame 8'hFF x16 -> result_data all ones.
- Macro undefined, 5 bytes then 100000 idle cycles then 11 bytes -> single valid word, frame_err never asserted.
